// File: rtl/repl_pkg.sv
// Shared types and helpers for the victim-way scheduler.
// Optional feature macro: REPL_HIT_SKIP_EN (consumed in repl_way_scheduler).
package repl_pkg;

    localparam int DEF_SETS = 16;
    localparam int DEF_WAYS = 4;

    // Widest way index the Gray helper handles; associativity above 256 is not expected.
    localparam int GRAY_W = 8;
    typedef logic [GRAY_W-1:0] gray_t;

    typedef enum logic [1:0] {
        IDLE,
        OFFER,
        FLUSH
    } state_t;

    function automatic gray_t bin2gray(input gray_t b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/repl_way_scheduler_if.sv
// Miss-path handshake and hit-report bundle between the cache controller and the scheduler.
interface repl_way_scheduler_if
    import repl_pkg::*;
#(
    parameter int SETS = DEF_SETS,
    parameter int WAYS = DEF_WAYS
);
    localparam int SET_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);

    logic             req_valid;
    logic [SET_W-1:0] req_set;
    logic             req_ready;
    logic             victim_valid;
    logic [SET_W-1:0] victim_set;
    logic [WAY_W-1:0] victim_way;
    logic             victim_ack;
    logic             hit_valid;
    logic [SET_W-1:0] hit_set;
    logic [WAY_W-1:0] hit_way;

    // Cache controller side.
    modport master (
        output req_valid, req_set, victim_ack, hit_valid, hit_set, hit_way,
        input  req_ready, victim_valid, victim_set, victim_way
    );

    // Scheduler side.
    modport slave (
        input  req_valid, req_set, victim_ack, hit_valid, hit_set, hit_way,
        output req_ready, victim_valid, victim_set, victim_way
    );

endinterface

// File: rtl/repl_counter_bank.sv
// Per-set replacement counters with two combinational read ports.
// Update priority per set: reset > clear > (ack-inc | hit-inc), where a
// simultaneous ack and hit on the same set collapse into a single increment.
module repl_counter_bank
    import repl_pkg::*;
#(
    parameter int SETS  = DEF_SETS,
    parameter int WAYS  = DEF_WAYS,
    parameter int SET_W = $clog2(SETS),
    parameter int WAY_W = $clog2(WAYS)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [SET_W-1:0] rd_set,
    output logic [WAY_W-1:0] rd_cnt,
    input  logic [SET_W-1:0] hit_set,
    output logic [WAY_W-1:0] hit_cnt,
    input  logic             inc,
    input  logic [SET_W-1:0] inc_set,
    input  logic             hit_inc,
    input  logic             clear,
    input  logic [SET_W-1:0] clear_set
);

    logic [WAY_W-1:0] cnt [SETS];

    assign rd_cnt  = cnt[rd_set];
    assign hit_cnt = cnt[hit_set];

    // Counter update: each set independently picks clear, one increment, or hold.
    always_ff @(posedge CLK) begin
        // NOTE: this array is reset on purpose -- a freshly reset set must offer way 0,
        // so the counters are architectural state, not scratch storage.
        if (RST) begin
            for (int s = 0; s < SETS; s++) begin
                cnt[s] <= '0;
            end
        end else begin
            for (int s = 0; s < SETS; s++) begin
                if (clear && clear_set == SET_W'(s)) begin
                    cnt[s] <= '0;
                end else if ((inc && inc_set == SET_W'(s)) ||
                             (hit_inc && hit_set == SET_W'(s))) begin
                    // Width WAY_W wraps modulo WAYS because WAYS is a power of two.
                    cnt[s] <= cnt[s] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/repl_way_scheduler.sv
// Victim-way scheduler: FSM, flush sequencer and handshake registers around
// the per-set counter bank. Victims follow the Gray code of each set counter.
// Optional feature macro: REPL_HIT_SKIP_EN -- when defined, a hit on the way
// a set would offer next advances that set's counter.
module repl_way_scheduler
    import repl_pkg::*;
#(
    parameter int SETS = DEF_SETS,
    parameter int WAYS = DEF_WAYS
) (
    input  logic                 CLK,
    input  logic                 RST,
    repl_way_scheduler_if.slave  bus,
    input  logic                 flush,
    output logic                 busy,
    output logic                 flush_done
);

    localparam int SET_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);

`ifdef REPL_HIT_SKIP_EN
    localparam bit HIT_SKIP = 1'b1;
`else
    localparam bit HIT_SKIP = 1'b0;
`endif

    function automatic logic [WAY_W-1:0] to_gray(input logic [WAY_W-1:0] b);
        return WAY_W'(bin2gray(gray_t'(b)));
    endfunction

    state_t           state_q, state_d;
    logic             flush_pending_q, flush_pending_d;
    logic [SET_W-1:0] flush_idx_q, flush_idx_d;
    logic [SET_W-1:0] victim_set_q, victim_set_d;
    logic [WAY_W-1:0] victim_way_q, victim_way_d;
    logic             flush_done_q, flush_done_d;

    logic [WAY_W-1:0] rd_cnt;
    logic [WAY_W-1:0] hit_cnt;
    logic             bank_inc;
    logic             bank_clear;
    logic             hit_inc;

    // Hits are independent of FSM state; the bank lets a same-cycle clear win.
    assign hit_inc = HIT_SKIP && bus.hit_valid && (bus.hit_way == to_gray(hit_cnt));

    repl_counter_bank #(
        .SETS  (SETS),
        .WAYS  (WAYS),
        .SET_W (SET_W),
        .WAY_W (WAY_W)
    ) u_bank (
        .CLK       (CLK),
        .RST       (RST),
        .rd_set    (bus.req_set),
        .rd_cnt    (rd_cnt),
        .hit_set   (bus.hit_set),
        .hit_cnt   (hit_cnt),
        .inc       (bank_inc),
        .inc_set   (victim_set_q),
        .hit_inc   (hit_inc),
        .clear     (bank_clear),
        .clear_set (flush_idx_q)
    );

    // Next-state, flush sequencing and victim capture.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves
        // a variable unassigned and no latch is inferred.
        state_d         = state_q;
        flush_pending_d = flush_pending_q;
        flush_idx_d     = flush_idx_q;
        victim_set_d    = victim_set_q;
        victim_way_d    = victim_way_q;
        flush_done_d    = 1'b0;
        bank_inc        = 1'b0;
        bank_clear      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (flush || flush_pending_q) begin
                    state_d         = FLUSH;
                    flush_pending_d = 1'b0;
                    flush_idx_d     = '0;
                end else if (bus.req_valid) begin
                    state_d      = OFFER;
                    victim_set_d = bus.req_set;
                    victim_way_d = to_gray(rd_cnt);
                end
            end
            OFFER: begin
                if (flush) begin
                    flush_pending_d = 1'b1;
                end
                if (bus.victim_ack) begin
                    bank_inc = 1'b1;
                    state_d  = IDLE;
                end
            end
            FLUSH: begin
                if (flush) begin
                    flush_pending_d = 1'b1;
                end
                bank_clear  = 1'b1;
                flush_idx_d = flush_idx_q + 1'b1;
                if (flush_idx_q == SET_W'(SETS - 1)) begin
                    state_d      = IDLE;
                    flush_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and handshake registers with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (RST) begin
            state_q         <= IDLE;
            flush_pending_q <= 1'b0;
            flush_idx_q     <= '0;
            victim_set_q    <= '0;
            victim_way_q    <= '0;
            flush_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            flush_pending_q <= flush_pending_d;
            flush_idx_q     <= flush_idx_d;
            victim_set_q    <= victim_set_d;
            victim_way_q    <= victim_way_d;
            flush_done_q    <= flush_done_d;
        end
    end

    // A pending or arriving flush takes priority, so no request is accepted then.
    assign bus.req_ready    = (state_q == IDLE) && !flush_pending_q && !flush;
    assign bus.victim_valid = (state_q == OFFER);
    assign bus.victim_set   = victim_set_q;
    assign bus.victim_way   = victim_way_q;
    assign busy             = (state_q != IDLE) || flush_pending_q;
    assign flush_done       = flush_done_q;

endmodule

// File: tb/tb_repl_way_scheduler.sv
// Self-checking bench for repl_way_scheduler: directed steps plus randomized
// request/hit traffic checked against a per-set counter model.
module tb_repl_way_scheduler;

    localparam int SETS  = 16;
    localparam int WAYS  = 4;
    localparam int SET_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);

`ifdef REPL_HIT_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST;
    logic flush;
    logic busy;
    logic flush_done;

    int checks = 0;
    int errors = 0;
    int cnt_m [SETS];

    repl_way_scheduler_if #(.SETS(SETS), .WAYS(WAYS)) bus ();

    repl_way_scheduler #(.SETS(SETS), .WAYS(WAYS)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .bus        (bus.slave),
        .flush      (flush),
        .busy       (busy),
        .flush_done (flush_done)
    );

    always #5 CLK = ~CLK;

    function automatic int gray(input int v);
        return v ^ (v >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) cnt_m[s] = 0;
    endtask

    // One clock edge of counter behaviour: ack advance, hit skip, same-set collapse.
    task automatic model_edge(input bit ack, input int as, input bit hv, input int hs, input int hw);
        bit hinc;
        hinc = SKIP && hv && (hw == gray(cnt_m[hs]));
        if (ack) cnt_m[as] = (cnt_m[as] + 1) % WAYS;
        if (hinc && !(ack && hs == as)) cnt_m[hs] = (cnt_m[hs] + 1) % WAYS;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_vvalid"}, bus.victim_valid, 0);
        check({tag, "_vset"}, bus.victim_set, 0);
        check({tag, "_vway"}, bus.victim_way, 0);
        check({tag, "_fdone"}, flush_done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_ready"}, bus.req_ready, 1);
    endtask

    // Full request/offer/ack transaction; exp < 0 means use the model's prediction.
    task automatic do_txn(input int s, input int waits, input bit hits, input int exp);
        int exp_way, hs, hw;
        bit hv, last;
        exp_way = (exp < 0) ? gray(cnt_m[s]) : exp;
        bus.req_valid = 1'b1;
        bus.req_set   = SET_W'(s);
        check("ready_idle", bus.req_ready, 1);
        tick();
        bus.req_valid = 1'b0;
        check("offer_valid", bus.victim_valid, 1);
        check("offer_set", bus.victim_set, s);
        check("offer_way", bus.victim_way, exp_way);
        check("offer_ready_low", bus.req_ready, 0);
        for (int i = 0; i <= waits; i++) begin
            last = (i == waits);
            hv = hits && ($urandom_range(0, 1) == 1);
            hs = $urandom_range(0, SETS - 1);
            hw = ($urandom_range(0, 1) == 1) ? gray(cnt_m[hs]) : int'($urandom_range(0, WAYS - 1));
            bus.hit_valid  = hv;
            bus.hit_set    = SET_W'(hs);
            bus.hit_way    = WAY_W'(hw);
            bus.victim_ack = last;
            model_edge(last, s, hv, hs, hw);
            tick();
            bus.hit_valid  = 1'b0;
            bus.victim_ack = 1'b0;
            if (!last) begin
                check("hold_valid", bus.victim_valid, 1);
                check("hold_way", bus.victim_way, exp_way);
            end
        end
        check("ack_valid_low", bus.victim_valid, 0);
        check("ack_ready_back", bus.req_ready, 1);
    endtask

    // Entered one cycle after FLUSH starts; returns sampling the flush_done cycle.
    task automatic flush_window();
        for (int i = 0; i < SETS; i++) begin
            check("flush_busy", busy, 1);
            check("flush_done_low", flush_done, 0);
            check("flush_ready_low", bus.req_ready, 0);
            tick();
        end
        check("flush_done_pulse", flush_done, 1);
        check("flush_busy_clear", busy, 0);
        model_clear();
    endtask

    initial begin
        int seq [5];
        int exp_way, hw;
        seq = '{0, 1, 3, 2, 0};

        RST = 1'b1;
        flush = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_set = '0;
        bus.victim_ack = 1'b0;
        bus.hit_valid = 1'b0;
        bus.hit_set = '0;
        bus.hit_way = '0;
        model_clear();
        repeat (2) tick();
        RST = 1'b0;
        tick();
        check_idle_outputs("reset");

        // Gray sequence on set 3.
        for (int k = 0; k < 5; k++) do_txn(3, k % 2, 1'b0, seq[k]);

        // Long stall on set 5 with a competing request for set 6.
        exp_way = gray(cnt_m[5]);
        bus.req_valid = 1'b1;
        bus.req_set = SET_W'(5);
        tick();
        bus.req_set = SET_W'(6);
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", bus.victim_valid, 1);
            check("stall_set", bus.victim_set, 5);
            check("stall_way", bus.victim_way, exp_way);
            check("stall_ready", bus.req_ready, 0);
            tick();
        end
        bus.victim_ack = 1'b1;
        bus.req_valid = 1'b0;
        model_edge(1'b1, 5, 1'b0, 0, 0);
        tick();
        bus.victim_ack = 1'b0;
        check("stall_ready_back", bus.req_ready, 1);
        do_txn(6, 0, 1'b0, -1);
        do_txn(5, 0, 1'b0, -1);

        // Flush from IDLE after advancing sets 0 and 15.
        for (int k = 0; k < 2; k++) begin
            do_txn(0, 0, 1'b0, -1);
            do_txn(15, 0, 1'b0, -1);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        flush_window();
        tick();
        check("flush_done_one_cycle", flush_done, 0);
        do_txn(0, 0, 1'b0, 0);
        do_txn(15, 0, 1'b0, 0);

        // Flush raised during OFFER, with a request queued behind it.
        bus.req_valid = 1'b1;
        bus.req_set = SET_W'(7);
        tick();
        bus.req_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("pend_busy", busy, 1);
        tick();
        bus.req_valid = 1'b1;
        bus.req_set = SET_W'(9);
        tick();
        bus.victim_ack = 1'b1;
        model_edge(1'b1, 7, 1'b0, 0, 0);
        tick();
        bus.victim_ack = 1'b0;
        check("pend_idle_valid", bus.victim_valid, 0);
        check("pend_idle_busy", busy, 1);
        check("pend_idle_ready", bus.req_ready, 0);
        tick();
        flush_window();
        check("pend_req_ready", bus.req_ready, 1);
        tick();
        bus.req_valid = 1'b0;
        check("pend_req_valid", bus.victim_valid, 1);
        check("pend_req_set", bus.victim_set, 9);
        check("pend_req_way", bus.victim_way, 0);
        bus.victim_ack = 1'b1;
        model_edge(1'b1, 9, 1'b0, 0, 0);
        tick();
        bus.victim_ack = 1'b0;

        // Hit skip on set 2.
        do_txn(2, 0, 1'b0, 0);
        bus.hit_valid = 1'b1;
        bus.hit_set = SET_W'(2);
        bus.hit_way = WAY_W'(1);
        model_edge(1'b0, 0, 1'b1, 2, 1);
        tick();
        bus.hit_valid = 1'b0;
        do_txn(2, 0, 1'b0, SKIP ? 3 : 1);
        bus.hit_valid = 1'b1;
        bus.hit_way = WAY_W'(0);
        model_edge(1'b0, 0, 1'b1, 2, 0);
        tick();
        bus.hit_valid = 1'b0;
        do_txn(2, 0, 1'b0, -1);

        // Hit on the offered set during OFFER, then hit and ack together.
        exp_way = gray(cnt_m[2]);
        bus.req_valid = 1'b1;
        bus.req_set = SET_W'(2);
        tick();
        bus.req_valid = 1'b0;
        hw = gray(cnt_m[2]);
        bus.hit_valid = 1'b1;
        bus.hit_set = SET_W'(2);
        bus.hit_way = WAY_W'(hw);
        model_edge(1'b0, 0, 1'b1, 2, hw);
        tick();
        check("offer_hit_way_stable", bus.victim_way, exp_way);
        hw = gray(cnt_m[2]);
        bus.hit_way = WAY_W'(hw);
        bus.victim_ack = 1'b1;
        model_edge(1'b1, 2, 1'b1, 2, hw);
        tick();
        bus.hit_valid = 1'b0;
        bus.victim_ack = 1'b0;
        do_txn(2, 0, 1'b0, -1);

        // Randomized traffic with random hits.
        for (int k = 0; k < 40; k++) begin
            do_txn($urandom_range(0, SETS - 1), $urandom_range(0, 3), 1'b1, -1);
        end

        // Reset during OFFER.
        bus.req_valid = 1'b1;
        bus.req_set = SET_W'(13);
        tick();
        bus.req_valid = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        model_clear();
        check_idle_outputs("rst_offer");

        // Reset mid-FLUSH after advancing every set.
        for (int s = 0; s < SETS; s++) do_txn(s, 0, 1'b0, -1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (5) tick();
        check("mid_flush_busy", busy, 1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        model_clear();
        check_idle_outputs("rst_flush");
        for (int s = 0; s < SETS; s++) do_txn(s, 0, 1'b0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
